lc3_decode: RTL and testbench
=============================

Name: lc3_decode

Overview:
- Decode stage of the LC3 pipeline, directly downstream of the fetch stage.
- Captures the instruction word returned by instruction memory (`dout`) together with the fetch stage's next-PC (`npc_in`).
- Registers both, and produces registered control bundles for the execute stage (`E_Control`), memory/controller (`Mem_Control`) and writeback (`W_Control`).
- Loads only when the controller asserts `enable_decode`. Supports a flush that injects a NOP bubble after a taken branch.

Parameters:
- `NOP_WORD`, 16'h0000, instruction word loaded on reset/flush (BR with nzp=000, architectural NOP).

Ports:
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `enable_decode`  in  1  capture `dout`/`npc_in` this cycle
- `flush`  in  1  discard the held instruction and load a bubble (taken branch)
- `dout`  in  16  instruction word from instruction memory
- `npc_in`  in  16  PC+1 of the fetched instruction, from fetch
- `IR`  out  16  registered instruction
- `npc_out`  out  16  registered `npc_in`
- `E_Control`  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- `W_Control`  out  2  writeback source select
- `Mem_Control`  out  1  1 = indirect memory op (LDI/STI)
- `decode_valid`  out  1  IR holds a real captured instruction
- `illegal_op`  out  1  IR opcode unsupported (JSR 0100, RTI 1000, reserved 1101, TRAP 1111)

Behaviour:
- Reset is synchronous and active-high, taking effect on `clock` edge:
  - `IR` = `NOP_WORD`; `npc_out`, `E_Control`, `W_Control`, `Mem_Control` = 0
  - `decode_valid` = 0, `illegal_op` = 0
- Priority per edge: `reset` > `flush` > `enable_decode` > hold.
- `flush`:
  - `IR` = `NOP_WORD`; all control = 0; `decode_valid` = 0; `illegal_op` = 0
  - `npc_out` holds its value
- `enable_decode` = 1 (no flush):
  - `IR` <= `dout`, `npc_out` <= `npc_in`
  - control outputs <= decode of `dout` (not the old `IR`)
  - `decode_valid` <= 1
  - Latency: exactly 1 cycle from input to all outputs.
- `enable_decode` = 0: all outputs hold, with no combinational path from inputs to outputs.
- Opcode decode on `dout[15:12]`:
  - `alu_control`: ADD 0001 -> 00, AND 0101 -> 01, NOT 1001 -> 10; all others 00.
  - `pcselect1`: BR/LD/LDI/LEA/ST/STI -> 01 (offset9); LDR/STR -> 10 (offset6); JMP -> 11 (zero); others 00.
  - `pcselect2`: 1 (NPC base) for BR/LD/LDI/LEA/ST/STI; 0 (BaseR) otherwise.
  - `op2select`: ADD/AND -> ~`dout[5]` (1 = register, 0 = imm5); NOT -> 1; others 0.
  - `W_Control`: ADD/AND/NOT -> 00 (ALU); LEA -> 01 (PC); LD/LDR/LDI -> 10 (memory); others 00.
  - `Mem_Control`: 1 for LDI 1010 and STI 1011, else 0.
  - Illegal opcodes:
    - all control fields = 0
    - `illegal_op` = 1 and `decode_valid` = 1
    - `IR` captured unchanged
- X on `dout` while `enable_decode` = 0 must not propagate to any output.

Decomposition:
- Shared package `lc3_pkg`:
  - opcode localparams (`OP_ADD`, `OP_AND`, `OP_NOT`, `OP_BR`, `OP_JMP`, `OP_LD`, `OP_LDR`, `OP_LDI`, `OP_LEA`, `OP_ST`, `OP_STR`, `OP_STI`)
  - `E_Control` field encodings (`ALU_*`, `PCSEL1_*`)
  - `W_Control` encodings (`WB_ALU`, `WB_PC`, `WB_MEM`)
  - field bit positions
- Execute and writeback import the same package.
- One combinational sub-module `lc3_ctrl_gen`: `dout` -> {E, W, Mem, illegal}.
- `lc3_decode` holds only the registers and the priority logic.

Test Plan:
- Reset held 2 cycles, then released with `enable_decode` = 0 -> `IR` = 16'h0000, all control 0, `decode_valid` = 0; outputs hold across 3 idle cycles.
- `enable_decode` = 1, `dout` = 16'h1261 (ADD R1,R1,#1), `npc_in` = 16'h3001 -> next edge: `IR` = 16'h1261, `npc_out` = 16'h3001, `E_Control` = 6'b000000, `W_Control` = 00, `Mem_Control` = 0, `decode_valid` = 1.
- Capture sequence 16'h5042 (AND reg), 16'hA405 (LDI), 16'h6283 (LDR), 16'hC1C0 (JMP), 16'hE3FE (LEA) -> `E_Control` = 010001, 000110, 001000, 001100, 000110; `W_Control` = 00, 10, 10, 00, 01; `Mem_Control` = 0, 1, 0, 0, 0.
- `flush` = 1 and `enable_decode` = 1 on the same edge with `dout` = 16'h1261 -> `IR` = 16'h0000, control 0, `decode_valid` = 0, `npc_out` unchanged.
- `dout` = 16'hF025 (TRAP) captured -> `illegal_op` = 1, `decode_valid` = 1, control all 0; a following legal capture clears `illegal_op`.
- Reset asserted mid-stream while `enable_decode` = 1 -> reset values on that edge regardless of `dout`.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcodes, control-field encodings and instruction bit positions.
// Imported by the decode, execute and writeback stages.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCSEL1_NONE    = 2'b00;
  localparam logic [1:0] PCSEL1_OFFSET9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFFSET6 = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO    = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC  = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int IMM_FLAG  = 5;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

endpackage

// File: rtl/lc3_ctrl_gen.sv
// Combinational opcode decoder: instruction word to execute/memory/writeback controls.
// Unsupported opcodes yield all-zero controls with illegal asserted.
module lc3_ctrl_gen
  import lc3_pkg::*;
(
  input  logic [15:0] instr,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        illegal
);

  logic [3:0] opcode;
  e_control_t e;

  assign opcode    = instr[OPCODE_HI:OPCODE_LO];
  assign e_control = e;

  always_comb begin
    e           = '0;
    w_control   = WB_ALU;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_ADD: begin
        e.alu_control = ALU_ADD;
        e.op2select   = ~instr[IMM_FLAG];
        w_control     = WB_ALU;
      end
      OP_AND: begin
        e.alu_control = ALU_AND;
        e.op2select   = ~instr[IMM_FLAG];
        w_control     = WB_ALU;
      end
      OP_NOT: begin
        e.alu_control = ALU_NOT;
        e.op2select   = 1'b1;
        w_control     = WB_ALU;
      end
      OP_BR, OP_ST: begin
        e.pcselect1 = PCSEL1_OFFSET9;
        e.pcselect2 = 1'b1;
      end
      OP_LD: begin
        e.pcselect1 = PCSEL1_OFFSET9;
        e.pcselect2 = 1'b1;
        w_control   = WB_MEM;
      end
      OP_LDI: begin
        e.pcselect1 = PCSEL1_OFFSET9;
        e.pcselect2 = 1'b1;
        w_control   = WB_MEM;
        mem_control = 1'b1;
      end
      OP_STI: begin
        e.pcselect1 = PCSEL1_OFFSET9;
        e.pcselect2 = 1'b1;
        mem_control = 1'b1;
      end
      OP_LEA: begin
        e.pcselect1 = PCSEL1_OFFSET9;
        e.pcselect2 = 1'b1;
        w_control   = WB_PC;
      end
      OP_LDR: begin
        e.pcselect1 = PCSEL1_OFFSET6;
        w_control   = WB_MEM;
      end
      OP_STR: e.pcselect1 = PCSEL1_OFFSET6;
      OP_JMP: e.pcselect1 = PCSEL1_ZERO;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: registers the fetched instruction and NPC plus its decoded controls.
// Per-edge priority is reset, then flush (bubble), then capture, else hold.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic        flush,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        decode_valid,
  output logic        illegal_op
);

  logic [5:0] e_next;
  logic [1:0] w_next;
  logic       mem_next;
  logic       illegal_next;

  lc3_ctrl_gen u_ctrl_gen (
    .instr       (dout),
    .e_control   (e_next),
    .w_control   (w_next),
    .mem_control (mem_next),
    .illegal     (illegal_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      IR           <= NOP_WORD;
      npc_out      <= '0;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (flush) begin
      // bubble: npc_out deliberately keeps its value
      IR           <= NOP_WORD;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_Control    <= e_next;
      W_Control    <= w_next;
      Mem_Control  <= mem_next;
      decode_valid <= 1'b1;
      illegal_op   <= illegal_next;
    end
  end

endmodule

// File: tb/tb_lc3_decode.sv
// Directed table-driven bench for lc3_decode with hand-written reset/flush/hold sequences.
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic        flush;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  int compared   = 0;
  int mismatched = 0;

  lc3_decode dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .flush        (flush),
    .dout         (dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control),
    .decode_valid (decode_valid),
    .illegal_op   (illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] dout;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        ill;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                         input logic [5:0] e, input logic [1:0] w, input logic mem,
                         input logic vld, input logic ill);
    chk({tag, ".IR"}, IR, ir);
    chk({tag, ".npc_out"}, npc_out, npc);
    chk({tag, ".E_Control"}, {10'd0, E_Control}, {10'd0, e});
    chk({tag, ".W_Control"}, {14'd0, W_Control}, {14'd0, w});
    chk({tag, ".Mem_Control"}, {15'd0, Mem_Control}, {15'd0, mem});
    chk({tag, ".decode_valid"}, {15'd0, decode_valid}, {15'd0, vld});
    chk({tag, ".illegal_op"}, {15'd0, illegal_op}, {15'd0, ill});
  endtask

  // Drive happens 1 time unit after a rising edge; sampling likewise after the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h1261, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b0}; // ADD imm
    vecs[1]  = '{16'h1241, 16'h3002, 6'b000001, 2'b00, 1'b0, 1'b0}; // ADD reg
    vecs[2]  = '{16'h5042, 16'h3003, 6'b010001, 2'b00, 1'b0, 1'b0}; // AND reg
    vecs[3]  = '{16'h5062, 16'h3004, 6'b010000, 2'b00, 1'b0, 1'b0}; // AND imm
    vecs[4]  = '{16'hA405, 16'h3005, 6'b000110, 2'b10, 1'b1, 1'b0}; // LDI
    vecs[5]  = '{16'h6283, 16'h3006, 6'b001000, 2'b10, 1'b0, 1'b0}; // LDR
    vecs[6]  = '{16'hC1C0, 16'h3007, 6'b001100, 2'b00, 1'b0, 1'b0}; // JMP
    vecs[7]  = '{16'hE3FE, 16'h3008, 6'b000110, 2'b01, 1'b0, 1'b0}; // LEA
    vecs[8]  = '{16'h927F, 16'h3009, 6'b100001, 2'b00, 1'b0, 1'b0}; // NOT
    vecs[9]  = '{16'h0E02, 16'h300A, 6'b000110, 2'b00, 1'b0, 1'b0}; // BR
    vecs[10] = '{16'h2005, 16'h300B, 6'b000110, 2'b10, 1'b0, 1'b0}; // LD
    vecs[11] = '{16'h3005, 16'h300C, 6'b000110, 2'b00, 1'b0, 1'b0}; // ST
    vecs[12] = '{16'hB005, 16'h300D, 6'b000110, 2'b00, 1'b1, 1'b0}; // STI
    vecs[13] = '{16'h7041, 16'h300E, 6'b001000, 2'b00, 1'b0, 1'b0}; // STR
    vecs[14] = '{16'h4800, 16'h300F, 6'b000000, 2'b00, 1'b0, 1'b1}; // JSR
    vecs[15] = '{16'h8000, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b1}; // RTI
    vecs[16] = '{16'hD000, 16'h3011, 6'b000000, 2'b00, 1'b0, 1'b1}; // reserved
    vecs[17] = '{16'hF025, 16'h3012, 6'b000000, 2'b00, 1'b0, 1'b1}; // TRAP
    vecs[18] = '{16'h1261, 16'h3013, 6'b000000, 2'b00, 1'b0, 1'b0}; // legal clears illegal

    reset = 1'b1; enable_decode = 1'b0; flush = 1'b0;
    dout = 16'hFFFF; npc_in = 16'hFFFF;
    step();
    step();
    reset = 1'b0;
    step();
    chk_all("reset", 16'h0000, 16'h0000, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      dout = 16'(16'hA405 + i); npc_in = 16'(16'h1234 + i);
      step();
      chk_all("idle", 16'h0000, 16'h0000, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 19; i++) begin
      enable_decode = 1'b1;
      dout = vecs[i].dout; npc_in = vecs[i].npc;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].npc,
              vecs[i].e, vecs[i].w, vecs[i].mem, 1'b1, vecs[i].ill);
    end

    // hold with changing inputs: ADD 1261 / 3013 must remain
    enable_decode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dout = 16'(16'hF000 | i); npc_in = 16'(16'hBEE0 + i);
      step();
      chk_all("hold", 16'h1261, 16'h3013, 6'b0, 2'b0, 1'b0, 1'b1, 1'b0);
    end

    // capture LDI then flush together with enable: npc_out keeps 3020
    enable_decode = 1'b1; dout = 16'hA405; npc_in = 16'h3020;
    step();
    chk_all("pre_flush", 16'hA405, 16'h3020, 6'b000110, 2'b10, 1'b1, 1'b1, 1'b0);
    flush = 1'b1; dout = 16'h1261; npc_in = 16'hBEEF;
    step();
    chk_all("flush", 16'h0000, 16'h3020, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; enable_decode = 1'b0;
    step();
    chk_all("post_flush", 16'h0000, 16'h3020, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);

    // flush clears a held illegal instruction
    enable_decode = 1'b1; dout = 16'hF025; npc_in = 16'h4000;
    step();
    chk_all("trap", 16'hF025, 16'h4000, 6'b0, 2'b0, 1'b0, 1'b1, 1'b1);
    enable_decode = 1'b0; flush = 1'b1;
    step();
    chk_all("flush_ill", 16'h0000, 16'h4000, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;

    // reset mid-stream beats enable and flush
    enable_decode = 1'b1; dout = 16'h6283; npc_in = 16'h5000;
    step();
    chk_all("pre_reset", 16'h6283, 16'h5000, 6'b001000, 2'b10, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; flush = 1'b1; dout = 16'hA405; npc_in = 16'h5001;
    step();
    chk_all("mid_reset", 16'h0000, 16'h0000, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; flush = 1'b0;
    step();
    chk_all("after_reset", 16'hA405, 16'h5001, 6'b000110, 2'b10, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
